// File: rtl/fib_bcd_conv_if.sv
// fib_bcd_conv_if: handshake and data bundle between the Fibonacci generator, the BCD converter and the display stage
interface fib_bcd_conv_if;
  logic        Valid;
  logic [9:0]  Bin;
  logic [15:0] Bcd;
  logic [3:0]  DigitEn;
  logic        Busy;
  logic        Ready;
  modport master (output Valid, Bin, input Bcd, DigitEn, Busy, Ready);
  modport slave  (input Valid, Bin, output Bcd, DigitEn, Busy, Ready);
endinterface

// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv: 10-bit binary to 4-digit packed BCD by double dabble, one bit per clock
// Define FIB_BCD_BLANK_EN to enable leading-zero blanking on DigitEn.
module fib_bcd_conv (
  input logic           Clk,
  input logic           Rst,
  fib_bcd_conv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic        valid_q, start;
  logic [9:0]  sr_q, sr_d;
  logic [15:0] scr_q, scr_d, bcd_q, bcd_d, adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, ready_q, ready_d;
  // every digit is adjusted from its pre-adjust value, all in parallel
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign adj[4*g +: 4] = scr_q[4*g +: 4] >= 4'd5 ? scr_q[4*g +: 4] + 4'd3 : scr_q[4*g +: 4];
  end
  assign start = bus.Valid & ~valid_q;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        sr_d    = bus.Bin;
        scr_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == 4'd10) begin
        bcd_d   = scr_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else begin
        scr_d = 16'({adj, sr_q[9]});
        sr_d  = {sr_q[8:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= bus.Valid;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
`ifdef FIB_BCD_BLANK_EN
  logic [3:0] en_q, en_d;
  // a digit lights if it or any higher digit is non-zero; ones always lit
  assign en_d = ready_d ? {|scr_q[15:12], |scr_q[15:8], |scr_q[15:4], 1'b1} : en_q;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) en_q <= 4'b0001;
    else      en_q <= en_d;
  assign bus.DigitEn = en_q;
`else
  assign bus.DigitEn = 4'b1111;
`endif
  assign bus.Bcd   = bcd_q;
  assign bus.Busy  = busy_q;
  assign bus.Ready = ready_q;
endmodule

// File: tb/tb_fib_bcd_conv.sv
// tb_fib_bcd_conv: directed checks of fib_bcd_conv timing, conversion results and start-edge handling
module tb_fib_bcd_conv;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  fib_bcd_conv_if bus ();
  fib_bcd_conv dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int busy_n, rdy_n, rdy_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input logic [3:0] blank);
`ifdef FIB_BCD_BLANK_EN
    return blank;
`else
    return 4'b1111;
`endif
  endfunction

  task automatic run(input int cycles, input int kill_at, input int restart_at, input logic [9:0] new_bin, input int change_at);
    busy_n = 0; rdy_n = 0; rdy_at = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge Clk);
      busy_n += int'(bus.Busy);
      if (bus.Ready) begin rdy_n++; rdy_at = i; end
      if (i == kill_at) bus.Valid = 1'b0;
      if (i == restart_at) begin bus.Valid = 1'b1; bus.Bin = new_bin; end
      if (i == restart_at + 1) bus.Valid = 1'b0;
      if (i == change_at) bus.Bin = new_bin;
    end
    bus.Valid = 1'b0;
  endtask

  task automatic conv(input string tag, input logic [9:0] bin, input logic [15:0] exp_bcd, input logic [3:0] blank);
    @(negedge Clk);
    bus.Bin = bin;
    bus.Valid = 1'b1;
    run(13, 0, 0, 10'd0, 0);
    check({tag, " busy cycles"}, busy_n, 11);
    check({tag, " ready count"}, rdy_n, 1);
    check({tag, " ready latency"}, rdy_at, 12);
    check({tag, " bcd"}, bus.Bcd, exp_bcd);
    check({tag, " digit_en"}, bus.DigitEn, exp_en(blank));
  endtask

  initial begin
    bus.Valid = 1'b0;
    bus.Bin = '0;
    repeat (3) @(negedge Clk);
    check("reset bcd", bus.Bcd, 16'h0000);
    check("reset digit_en", bus.DigitEn, exp_en(4'b0001));
    check("reset busy", bus.Busy, 1'b0);
    check("reset ready", bus.Ready, 1'b0);
    Rst = 1'b1;
    conv("bin0", 10'd0, 16'h0000, 4'b0001);
    conv("bin987", 10'd987, 16'h0987, 4'b0111);
    conv("bin1023", 10'd1023, 16'h1023, 4'b1111);
    conv("bin55", 10'd55, 16'h0055, 4'b0011);
    // level held 40 cycles, Bin changed after capture
    @(negedge Clk);
    bus.Bin = 10'd377;
    bus.Valid = 1'b1;
    run(40, 41, 0, 10'd100, 5);
    check("hold ready count", rdy_n, 1);
    check("hold bcd", bus.Bcd, 16'h0377);
    check("hold digit_en", bus.DigitEn, exp_en(4'b0111));
    // second rising edge mid-conversion is ignored
    @(negedge Clk);
    bus.Bin = 10'd144;
    bus.Valid = 1'b1;
    run(14, 1, 5, 10'd0, 0);
    check("retrig ready count", rdy_n, 1);
    check("retrig ready latency", rdy_at, 12);
    check("retrig bcd", bus.Bcd, 16'h0144);
    conv("bin233", 10'd233, 16'h0233, 4'b0111);
    // reset mid-conversion of 610
    @(negedge Clk);
    bus.Bin = 10'd610;
    bus.Valid = 1'b1;
    run(6, 1, 0, 10'd0, 0);
    check("pre-kill busy", bus.Busy, 1'b1);
    Rst = 1'b0;
    #1;
    check("kill bcd", bus.Bcd, 16'h0000);
    check("kill digit_en", bus.DigitEn, exp_en(4'b0001));
    check("kill busy", bus.Busy, 1'b0);
    check("kill ready", bus.Ready, 1'b0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    run(14, 0, 0, 10'd0, 0);
    check("post-kill ready count", rdy_n, 0);
    check("post-kill busy cycles", busy_n, 0);
    conv("bin610", 10'd610, 16'h0610, 4'b0111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
